// File: rtl/xnor4_pkg.sv
// Shared types and constants for the xnor4 arbiter slice: operand width,
// result-slot state and requester identifier.
package xnor4_pkg;

  localparam int DATA_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/xnor4.sv
// Bitwise XNOR of two DATA_W-bit operands; the single compute unit shared by
// both requesters of xnor4_arbiter.
module xnor4
  import xnor4_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/xnor4_arbiter.sv
// Two-requester round-robin front end to one shared xnor4 unit with a single
// registered result slot. Optional per-requester match counters are enabled
// by defining XNOR4_ARBITER_MATCH_CNT_EN.
module xnor4_arbiter
  import xnor4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_y,
  output logic              res_id,
  input  logic              res_ready
`ifdef XNOR4_ARBITER_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]  match_cnt0,
  output logic [CNT_W-1:0]  match_cnt1
`endif
);

  state_t            state_r;
  req_id_t           last_grant_r;
  req_id_t           res_id_r;
  logic [DATA_W-1:0] res_y_r;

  req_id_t           grant_s;
  logic              slot_free_s;
  logic              accept_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] y_s;

  // Grant selection, handshake and operand steering into the shared unit.
  always_comb begin
    grant_s     = REQ0;
    slot_free_s = (state_r == EMPTY) || res_ready;
    if (req0_valid && req1_valid) begin
      grant_s = (last_grant_r == REQ1) ? REQ0 : REQ1;
    end else if (req1_valid) begin
      grant_s = REQ1;
    end else begin
      grant_s = REQ0;
    end
    // Readies are gated by rst_n so nothing is accepted while reset is held.
    req0_ready = rst_n && slot_free_s && req0_valid && (grant_s == REQ0);
    req1_ready = rst_n && slot_free_s && req1_valid && (grant_s == REQ1);
    accept_s   = req0_ready || req1_ready;
    if (grant_s == REQ1) begin
      op_a_s = req1_a;
      op_b_s = req1_b;
    end else begin
      op_a_s = req0_a;
      op_b_s = req0_b;
    end
  end

  xnor4 u_xnor4 (
    .a (op_a_s),
    .b (op_b_s),
    .y (y_s)
  );

  // Result slot FSM with registered result and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= EMPTY;
      res_y_r      <= {DATA_W{1'b0}};
      res_id_r     <= REQ0;
      last_grant_r <= REQ1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r      <= FULL;
            res_y_r      <= y_s;
            res_id_r     <= grant_s;
            last_grant_r <= grant_s;
          end
        end
        FULL: begin
          if (accept_s) begin
            res_y_r      <= y_s;
            res_id_r     <= grant_s;
            last_grant_r <= grant_s;
          end else if (res_ready) begin
            state_r <= EMPTY;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  assign res_valid = (state_r == FULL);
  assign res_y     = res_y_r;
  assign res_id    = res_id_r;

`ifdef XNOR4_ARBITER_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  // Saturating count of accepted equal-operand pairs per requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else if (accept_s && (y_s == {DATA_W{1'b1}})) begin
      if (grant_s == REQ0) begin
        if (cnt0_r != CNT_MAX) cnt0_r <= cnt0_r + CNT_ONE;
      end else begin
        if (cnt1_r != CNT_MAX) cnt1_r <= cnt1_r + CNT_ONE;
      end
    end
  end

  assign match_cnt0 = cnt0_r;
  assign match_cnt1 = cnt1_r;
`else
  // CNT_W only sizes the absent counters.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_xnor4_arbiter.sv
// Self-checking bench for xnor4_arbiter: directed vector table, then random
// traffic against a transaction-level reference model.
module tb_xnor4_arbiter;

  localparam int CW = 2;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       res_valid;
  logic [3:0] res_y;
  logic       res_id;
  logic       res_ready;
`ifdef XNOR4_ARBITER_MATCH_CNT_EN
  logic [CW-1:0] match_cnt0, match_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  xnor4_arbiter #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_y      (res_y),
    .res_id     (res_id),
    .res_ready  (res_ready)
`ifdef XNOR4_ARBITER_MATCH_CNT_EN
    ,
    .match_cnt0 (match_cnt0),
    .match_cnt1 (match_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       v1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       rr;
    logic       e_rdy0;
    logic       e_rdy1;
    logic       e_vld;
    logic       chk_y;
    logic [3:0] e_y;
    logic       e_id;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst_n = v.rst; req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; res_ready = v.rr;
    #1;
    chk($sformatf("vec%0d_req0_ready", idx), 32'(req0_ready), 32'(v.e_rdy0));
    chk($sformatf("vec%0d_req1_ready", idx), 32'(req1_ready), 32'(v.e_rdy1));
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_res_valid", idx), 32'(res_valid), 32'(v.e_vld));
    if (v.chk_y) begin
      chk($sformatf("vec%0d_res_y", idx), 32'(res_y), 32'(v.e_y));
      chk($sformatf("vec%0d_res_id", idx), 32'(res_id), 32'(v.e_id));
    end
  endtask

  // Reference model state: one result slot, last winner, match counts.
  int m_has, m_y, m_id, m_last;
  int m_cnt[2];

  initial begin
    int free, w, e0, e1, a, b;
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_a = 4'h0; req0_b = 4'h0; req1_a = 4'h0; req1_b = 4'h0;
    @(posedge clk);
    #1;

    vecs[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'hF, 4'hA, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 4'hA, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 4'hA, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 4'hC, 4'h6, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0};
    vecs[10] = vecs[9];
    vecs[11] = vecs[9];
    vecs[12] = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 4'hA, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1};

    for (int i = 0; i < 17; i++) apply(vecs[i], i);

`ifdef XNOR4_ARBITER_MATCH_CNT_EN
    // Counter sequence: reset, then five equal-operand transfers from req1.
    begin
      int exp_c1[5];
      exp_c1 = '{1, 2, 3, 3, 3};
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("cnt0_after_reset", 32'(match_cnt0), 32'd0);
      chk("cnt1_after_reset", 32'(match_cnt1), 32'd0);
      rst_n = 1'b1; req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h7;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        chk($sformatf("cnt1_step%0d", k), 32'(match_cnt1), 32'(exp_c1[k]));
        chk($sformatf("cnt0_step%0d", k), 32'(match_cnt0), 32'd0);
      end
    end
`endif

    // Random traffic against the reference model, starting from reset.
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;
    m_has = 0; m_y = 0; m_id = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
    for (int n = 0; n < 400; n++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a     = 4'($urandom_range(0, 15));
      req0_b     = ($urandom_range(0, 2) == 0) ? req0_a : 4'($urandom_range(0, 15));
      req1_a     = 4'($urandom_range(0, 15));
      req1_b     = ($urandom_range(0, 2) == 0) ? req1_a : 4'($urandom_range(0, 15));
      res_ready  = ($urandom_range(0, 2) != 0);
      e0 = 0; e1 = 0; free = 0; w = 0;
      if (rst_n) begin
        free = (m_has == 0 || res_ready) ? 1 : 0;
        if (req0_valid && req1_valid) w = 1 - m_last;
        else w = req1_valid ? 1 : 0;
        e0 = (free == 1 && req0_valid && w == 0) ? 1 : 0;
        e1 = (free == 1 && req1_valid && w == 1) ? 1 : 0;
      end
      #1;
      chk($sformatf("rnd%0d_req0_ready", n), 32'(req0_ready), 32'(e0));
      chk($sformatf("rnd%0d_req1_ready", n), 32'(req1_ready), 32'(e1));
      @(posedge clk);
      if (!rst_n) begin
        m_has = 0; m_y = 0; m_id = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
      end else if (e0 == 1 || e1 == 1) begin
        a = (w == 1) ? int'(req1_a) : int'(req0_a);
        b = (w == 1) ? int'(req1_b) : int'(req0_b);
        m_has = 1; m_y = (~(a ^ b)) & 15; m_id = w; m_last = w;
        if (a == b && m_cnt[w] < (1 << CW) - 1) m_cnt[w] = m_cnt[w] + 1;
      end else if (free == 1) begin
        m_has = 0;
      end
      #1;
      chk($sformatf("rnd%0d_res_valid", n), 32'(res_valid), 32'(m_has));
      if (m_has == 1 || !rst_n) begin
        chk($sformatf("rnd%0d_res_y", n), 32'(res_y), 32'(m_y));
        chk($sformatf("rnd%0d_res_id", n), 32'(res_id), 32'(m_id));
      end
`ifdef XNOR4_ARBITER_MATCH_CNT_EN
      chk($sformatf("rnd%0d_cnt0", n), 32'(match_cnt0), 32'(m_cnt[0]));
      chk($sformatf("rnd%0d_cnt1", n), 32'(match_cnt1), 32'(m_cnt[1]));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
